// File: rtl/pixel_sink.sv
// pixel_sink: captures painter pixel strobes into a small FIFO and drains them into a
// single-port frame buffer shared with VGA scan-out reads and a full-screen clear sweep.
module pixel_sink #(
   parameter int SCR_WIDTH  = 160,
   parameter int SCR_HEIGHT = 120,
   parameter int X_BITS     = 8,
   parameter int Y_BITS     = 7,
   parameter int COLOR_SIZE = 3,
   parameter int ADDR_BITS  = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          Clck,
   input  logic                          Reset,
   input  logic [X_BITS-1:0]             paint_x_co,
   input  logic [Y_BITS-1:0]             paint_y_co,
   input  logic [COLOR_SIZE-1:0]         color,
   input  logic                          print_enable,
   input  logic                          scan_req,
   input  logic [ADDR_BITS-1:0]          scan_addr,
   output logic [COLOR_SIZE-1:0]         scan_data,
   output logic                          scan_valid,
   input  logic                          clear_req,
   input  logic [COLOR_SIZE-1:0]         clear_color,
   output logic                          clear_done,
   output logic [ADDR_BITS-1:0]          mem_addr,
   output logic [COLOR_SIZE-1:0]         mem_wdata,
   output logic                          mem_we,
   input  logic [COLOR_SIZE-1:0]         mem_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [7:0]                    oob_drops
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SCR_WIDTH * SCR_HEIGHT - 1);
   localparam logic [X_BITS:0]      X_LIMIT   = (X_BITS + 1)'(SCR_WIDTH);
   localparam logic [Y_BITS:0]      Y_LIMIT   = (Y_BITS + 1)'(SCR_HEIGHT);
   localparam logic [CNT_BITS-1:0]  CNT_FULL  = CNT_BITS'(FIFO_DEPTH);

   logic                  pe_q;
   logic [X_BITS-1:0]     fx_q [FIFO_DEPTH];
   logic [Y_BITS-1:0]     fy_q [FIFO_DEPTH];
   logic [COLOR_SIZE-1:0] fc_q [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;

   logic                  clr_active_q, clr_active_d;
   logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
   logic [COLOR_SIZE-1:0] clr_color_q, clr_color_d;
   logic                  clr_last_q, clr_last_d;
   logic                  clear_done_q;

   logic                  rd_p1_q, rd_p2_q;
   logic                  scan_valid_q;
   logic [COLOR_SIZE-1:0] scan_data_q, scan_data_d;

   logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
   logic [COLOR_SIZE-1:0] mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q, mem_we_d;

   logic                  overflow_q, overflow_d;
   logic [7:0]            oob_q, oob_d;

   logic                  strobe_s, oob_s, full_s, empty_s, pop_s, push_s;
   logic [ADDR_BITS-1:0]  pix_addr_s;

   // Strobe edge detection, range check and FIFO push/pop decisions
   always_comb begin
      strobe_s   = print_enable & ~pe_q;
      oob_s      = ({1'b0, paint_x_co} >= X_LIMIT) | ({1'b0, paint_y_co} >= Y_LIMIT);
      full_s     = (cnt_q == CNT_FULL);
      empty_s    = (cnt_q == CNT_BITS'(0));
      pop_s      = ~scan_req & ~clr_active_q & ~empty_s;
      push_s     = strobe_s & ~oob_s & (~full_s | pop_s);
      // widen both terms before the multiply so y*WIDTH+x never wraps early
      pix_addr_s = ADDR_BITS'(fy_q[rd_ptr_q]) * ADDR_BITS'(SCR_WIDTH)
                 + ADDR_BITS'(fx_q[rd_ptr_q]);
   end

   // FIFO pointers, occupancy and drop bookkeeping
   always_comb begin
      wr_ptr_d   = push_s ? (wr_ptr_q + PTR_BITS'(1)) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_BITS'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_BITS'(1);
         2'b01:   cnt_d = cnt_q - CNT_BITS'(1);
         default: cnt_d = cnt_q;
      endcase
      overflow_d = overflow_q | (strobe_s & ~oob_s & full_s & ~pop_s);
      if (strobe_s && oob_s && (oob_q != 8'hFF)) begin
         oob_d = oob_q + 8'd1;
      end else begin
         oob_d = oob_q;
      end
   end

   // RAM port arbitration: scan read, then clear sweep, then queued pixel
   always_comb begin
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      clr_active_d = clr_active_q;
      clr_addr_d   = clr_addr_q;
      clr_color_d  = clr_color_q;
      clr_last_d   = 1'b0;
      if (scan_req) begin
         mem_addr_d = scan_addr;
      end else if (clr_active_q) begin
         mem_addr_d  = clr_addr_q;
         mem_wdata_d = clr_color_q;
         mem_we_d    = 1'b1;
         if (clr_addr_q == LAST_ADDR) begin
            clr_active_d = 1'b0;
            clr_last_d   = 1'b1;
         end else begin
            clr_addr_d = clr_addr_q + ADDR_BITS'(1);
         end
      end else if (!empty_s) begin
         mem_addr_d  = pix_addr_s;
         mem_wdata_d = fc_q[rd_ptr_q];
         mem_we_d    = 1'b1;
      end else begin
         mem_we_d = 1'b0;
      end
      // a new request restarts the sweep and suppresses done for the aborted one
      if (clear_req) begin
         clr_active_d = 1'b1;
         clr_addr_d   = ADDR_BITS'(0);
         clr_color_d  = clear_color;
         clr_last_d   = 1'b0;
      end else begin
         clr_color_d = clr_color_q;
      end
   end

   // Read-data capture two edges after the request was sampled
   always_comb begin
      if (rd_p2_q) begin
         scan_data_d = mem_rdata;
      end else begin
         scan_data_d = scan_data_q;
      end
   end

   // Control and output registers
   always_ff @(posedge Clck or posedge Reset) begin
      if (Reset) begin
         pe_q         <= 1'b0;
         wr_ptr_q     <= PTR_BITS'(0);
         rd_ptr_q     <= PTR_BITS'(0);
         cnt_q        <= CNT_BITS'(0);
         clr_active_q <= 1'b0;
         clr_addr_q   <= ADDR_BITS'(0);
         clr_color_q  <= COLOR_SIZE'(0);
         clr_last_q   <= 1'b0;
         clear_done_q <= 1'b0;
         rd_p1_q      <= 1'b0;
         rd_p2_q      <= 1'b0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= COLOR_SIZE'(0);
         mem_addr_q   <= ADDR_BITS'(0);
         mem_wdata_q  <= COLOR_SIZE'(0);
         mem_we_q     <= 1'b0;
         overflow_q   <= 1'b0;
         oob_q        <= 8'd0;
      end else begin
         pe_q         <= print_enable;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         clr_active_q <= clr_active_d;
         clr_addr_q   <= clr_addr_d;
         clr_color_q  <= clr_color_d;
         clr_last_q   <= clr_last_d;
         clear_done_q <= clr_last_q;
         rd_p1_q      <= scan_req;
         rd_p2_q      <= rd_p1_q;
         scan_valid_q <= rd_p2_q;
         scan_data_q  <= scan_data_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         overflow_q   <= overflow_d;
         oob_q        <= oob_d;
      end
   end

   // Pixel storage; contents are only meaningful below the occupancy count
   always_ff @(posedge Clck) begin
      if (push_s) begin
         fx_q[wr_ptr_q] <= paint_x_co;
         fy_q[wr_ptr_q] <= paint_y_co;
         fc_q[wr_ptr_q] <= color;
      end
   end

   assign scan_data  = scan_data_q;
   assign scan_valid = scan_valid_q;
   assign clear_done = clear_done_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign fifo_count = cnt_q;
   assign overflow   = overflow_q;
   assign oob_drops  = oob_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Bench for pixel_sink: directed scenarios plus randomized traffic against a
// transaction-level model (pixel queue, shadow frame buffer, read delay line).
module tb_pixel_sink;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int DEPTH = 4;
   localparam int NPIX  = W * H;

   logic        Clck;
   logic        Reset;
   logic [7:0]  paint_x_co;
   logic [6:0]  paint_y_co;
   logic [2:0]  color;
   logic        print_enable;
   logic        scan_req;
   logic [14:0] scan_addr;
   logic [2:0]  scan_data;
   logic        scan_valid;
   logic        clear_req;
   logic [2:0]  clear_color;
   logic        clear_done;
   logic [14:0] mem_addr;
   logic [2:0]  mem_wdata;
   logic        mem_we;
   logic [2:0]  mem_rdata;
   logic [2:0]  fifo_count;
   logic        overflow;
   logic [7:0]  oob_drops;

   pixel_sink dut (
      .Clck(Clck), .Reset(Reset),
      .paint_x_co(paint_x_co), .paint_y_co(paint_y_co), .color(color),
      .print_enable(print_enable),
      .scan_req(scan_req), .scan_addr(scan_addr),
      .scan_data(scan_data), .scan_valid(scan_valid),
      .clear_req(clear_req), .clear_color(clear_color), .clear_done(clear_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .fifo_count(fifo_count), .overflow(overflow), .oob_drops(oob_drops)
   );

   initial Clck = 1'b0;
   always #5 Clck = ~Clck;

   // synchronous single-port RAM, 1-cycle read latency
   logic [2:0] ram [0:32767];
   always @(posedge Clck) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_qa[$];
   int m_qc[$];
   bit m_pe, m_clr, m_last, m_p1, m_p2;
   int m_clr_addr, m_clr_col, m_d1, m_d2;
   int e_we, e_addr, e_wdata, e_cnt, e_ovf, e_oob, e_done, e_valid, e_sdata;
   int shadow [0:32767];
   bit sh_ok  [0:32767];

   task automatic model_reset();
      m_qa.delete(); m_qc.delete();
      m_pe = 0; m_clr = 0; m_last = 0; m_p1 = 0; m_p2 = 0;
      m_clr_addr = 0; m_clr_col = 0; m_d1 = 0; m_d2 = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_cnt = 0; e_ovf = 0; e_oob = 0;
      e_done = 0; e_valid = 0; e_sdata = 0;
   endtask

   task automatic m_write(input int a, input int c);
      e_we = 1; e_addr = a; e_wdata = c;
      shadow[a] = c; sh_ok[a] = 1'b1;
   endtask

   // predicts the outputs following the next rising edge from the current inputs
   task automatic model_step();
      bit strobe, last_now;
      strobe = print_enable && !m_pe;
      m_pe = print_enable;
      last_now = 0;
      e_valid = m_p2;
      if (m_p2) e_sdata = m_d2;
      m_p2 = m_p1; m_d2 = m_d1;
      m_p1 = scan_req;
      e_done = m_last;
      e_we = 0;
      if (scan_req) begin
         e_addr = scan_addr;
         m_d1 = sh_ok[scan_addr] ? shadow[scan_addr] : -1;
      end else if (m_clr) begin
         m_write(m_clr_addr, m_clr_col);
         if (m_clr_addr == NPIX - 1) begin
            m_clr = 0; last_now = 1;
         end else m_clr_addr++;
      end else if (m_qa.size() != 0) begin
         m_write(m_qa.pop_front(), m_qc.pop_front());
      end
      if (clear_req) begin
         m_clr = 1; m_clr_addr = 0; m_clr_col = clear_color; last_now = 0;
      end
      m_last = last_now;
      if (strobe) begin
         if (paint_x_co >= W || paint_y_co >= H) begin
            if (e_oob < 255) e_oob++;
         end else if (m_qa.size() == DEPTH) e_ovf = 1;
         else begin
            m_qa.push_back(paint_y_co * W + paint_x_co);
            m_qc.push_back(color);
         end
      end
      e_cnt = m_qa.size();
   endtask

   int n_writes, n_done, last_waddr, last_wdata;

   task automatic tick();
      model_step();
      @(posedge Clck);
      #1;
      chk_eq("mem_we", mem_we, e_we);
      chk_eq("mem_addr", mem_addr, e_addr);
      if (e_we != 0) chk_eq("mem_wdata", mem_wdata, e_wdata);
      chk_eq("fifo_count", fifo_count, e_cnt);
      chk_eq("overflow", overflow, e_ovf);
      chk_eq("oob_drops", oob_drops, e_oob);
      chk_eq("clear_done", clear_done, e_done);
      chk_eq("scan_valid", scan_valid, e_valid);
      if (e_valid != 0 && e_sdata >= 0) chk_eq("scan_data", scan_data, e_sdata);
      if (mem_we) begin
         n_writes++; last_waddr = mem_addr; last_wdata = mem_wdata;
      end
      if (clear_done) n_done++;
   endtask

   task automatic strobe_px(input int x, input int y, input int c);
      paint_x_co = 8'(x); paint_y_co = 7'(y); color = 3'(c);
      print_enable = 1'b1; tick();
      print_enable = 1'b0; tick();
   endtask

   task automatic rnd_cycle();
      print_enable = ($urandom_range(0, 99) < 40);
      paint_x_co   = 8'($urandom_range(0, 175));
      paint_y_co   = 7'($urandom_range(0, 127));
      color        = 3'($urandom_range(0, 7));
      scan_req     = ($urandom_range(0, 99) < 30);
      scan_addr    = 15'($urandom_range(0, NPIX - 1));
      tick();
   endtask

   int n_c1;

   initial begin
      Reset = 1'b1; print_enable = 1'b0; paint_x_co = 8'd0; paint_y_co = 7'd0;
      color = 3'd0; scan_req = 1'b0; scan_addr = 15'd0; clear_req = 1'b0; clear_color = 3'd0;
      n_writes = 0; n_done = 0; last_waddr = 0; last_wdata = 0;
      for (int a = 0; a < 32768; a++) begin shadow[a] = 0; sh_ok[a] = 1'b0; end
      model_reset();
      repeat (3) @(posedge Clck);
      #1;
      chk_eq("rst_mem_we", mem_we, 0);
      chk_eq("rst_mem_addr", mem_addr, 0);
      chk_eq("rst_fifo_count", fifo_count, 0);
      chk_eq("rst_scan_valid", scan_valid, 0);
      chk_eq("rst_oob", oob_drops, 0);
      #1 Reset = 1'b0;

      // 1: long strobe gives one write at 2*160+5
      n_writes = 0;
      paint_x_co = 8'd5; paint_y_co = 7'd2; color = 3'b110; print_enable = 1'b1;
      repeat (3) tick();
      print_enable = 1'b0;
      repeat (3) tick();
      chk_eq("t1_writes", n_writes, 1);
      chk_eq("t1_addr", last_waddr, 325);
      chk_eq("t1_wdata", last_wdata, 6);
      chk_eq("t1_fifo", fifo_count, 0);

      // 2: out-of-range drops, saturating
      n_writes = 0;
      strobe_px(160, 0, 1);
      strobe_px(0, 120, 1);
      chk_eq("t2_oob2", oob_drops, 2);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 1) strobe_px($urandom_range(160, 255), $urandom_range(0, 127), 2);
         else strobe_px($urandom_range(0, 255), $urandom_range(120, 127), 2);
      end
      chk_eq("t2_oob_sat", oob_drops, 255);
      chk_eq("t2_writes", n_writes, 0);

      // 3: scan hold stalls writes, FIFO fills and overflows
      n_writes = 0;
      scan_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         scan_addr = 15'($urandom_range(0, NPIX - 1));
         strobe_px($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));
      end
      chk_eq("t3_fifo_full", fifo_count, 4);
      chk_eq("t3_overflow", overflow, 1);
      chk_eq("t3_no_writes", n_writes, 0);
      scan_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_eq("t3_consec_we", mem_we, 1);
      end
      repeat (2) tick();
      chk_eq("t3_writes", n_writes, 4);

      // 4: back-to-back reads of 1,2,3
      strobe_px(0, 0, 1); strobe_px(1, 0, 2); strobe_px(2, 0, 3);
      repeat (3) tick();
      scan_req = 1'b1; scan_addr = 15'd0; tick();
      chk_eq("t4_v0", scan_valid, 0);
      scan_addr = 15'd1; tick();
      chk_eq("t4_v1", scan_valid, 0);
      scan_addr = 15'd2; tick();
      chk_eq("t4_v2", scan_valid, 1); chk_eq("t4_d0", scan_data, 1);
      scan_req = 1'b0; tick();
      chk_eq("t4_v3", scan_valid, 1); chk_eq("t4_d1", scan_data, 2);
      tick();
      chk_eq("t4_v4", scan_valid, 1); chk_eq("t4_d2", scan_data, 3);
      tick();
      chk_eq("t4_v5", scan_valid, 0);

      // 5: full clear with a pixel captured mid-sweep
      n_done = 0; n_c1 = 0;
      clear_req = 1'b1; clear_color = 3'b001; tick();
      clear_req = 1'b0;
      for (int i = 0; i < 25000 && n_done == 0; i++) begin
         paint_x_co = 8'd7; paint_y_co = 7'd3; color = 3'd5;
         print_enable = (i == 100);
         tick();
         if (mem_we && mem_wdata == 3'd1) n_c1++;
      end
      print_enable = 1'b0;
      chk_eq("t5_clear_writes", n_c1, NPIX);
      repeat (3) tick();
      chk_eq("t5_done_once", n_done, 1);
      chk_eq("t5_px_addr", last_waddr, 3 * W + 7);
      chk_eq("t5_px_data", last_wdata, 5);

      // randomized traffic with an aborted and a completed clear
      for (int i = 0; i < 200; i++) rnd_cycle();
      n_done = 0;
      clear_req = 1'b1; clear_color = 3'($urandom_range(0, 7)); rnd_cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 60; i++) rnd_cycle();
      clear_req = 1'b1; clear_color = 3'($urandom_range(0, 7)); rnd_cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 40000 && n_done == 0; i++) rnd_cycle();
      chk_eq("rnd_done", n_done, 1);
      for (int i = 0; i < 200; i++) rnd_cycle();
      chk_eq("rnd_done_once", n_done, 1);

      // 6: asynchronous reset during a clear with queued pixels
      print_enable = 1'b0; scan_req = 1'b0;
      repeat (10) tick();
      clear_req = 1'b1; clear_color = 3'd2; tick();
      clear_req = 1'b0;
      strobe_px(10, 10, 4); strobe_px(20, 20, 5);
      chk_eq("t6_pre_cnt", fifo_count, 2);
      chk_eq("t6_pre_we", mem_we, 1);
      #2 Reset = 1'b1;
      #1;
      chk_eq("t6_async_we", mem_we, 0);
      chk_eq("t6_async_cnt", fifo_count, 0);
      chk_eq("t6_async_ovf", overflow, 0);
      chk_eq("t6_async_oob", oob_drops, 0);
      model_reset();
      @(posedge Clck); @(posedge Clck);
      #2 Reset = 1'b0;
      n_writes = 0;
      repeat (20) tick();
      chk_eq("t6_no_writes", n_writes, 0);
      chk_eq("t6_cnt", fifo_count, 0);
      chk_eq("t6_ovf", overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
